// File: rtl/pcu_btb_fetch_pkg.sv
// Shared types and sizing helpers for the kv32 fetch-stage PC unit.
package kv32_pcu_pkg;

  typedef enum logic [1:0] {RD_NONE, RD_BR, RD_TRAP} redirect_src_e;

  typedef enum logic {BOOT, RUN} fsm_e;

  localparam int unsigned PC_STEP = 4;

  // Index width used for the storage array; at least one bit so a
  // single-entry table still has a legal index vector.
  function automatic int unsigned btb_idx_w(int unsigned entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  // Number of PC bits consumed by the index (zero for a single entry).
  function automatic int unsigned btb_idx_bits(int unsigned entries);
    return (entries > 1) ? $clog2(entries) : 0;
  endfunction

  // Tag covers every PC bit above the index and the two word-offset bits.
  function automatic int unsigned btb_tag_w(int unsigned xlen, int unsigned entries);
    return xlen - btb_idx_bits(entries) - 2;
  endfunction

  // Width of one packed {valid, tag, target} entry.
  function automatic int unsigned btb_entry_w(int unsigned xlen, int unsigned entries);
    return 1 + btb_tag_w(xlen, entries) + xlen;
  endfunction

endpackage

// File: rtl/pcu_btb.sv
// Direct-mapped branch target buffer: combinational lookup, edge-written
// install/invalidate, whole-table flush. A write is seen by lookup only from
// the following cycle.
module pcu_btb
  import kv32_pcu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            hit,
  output logic [XLEN-1:0] target,
  input  logic            upd_v,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  input  logic            flush
);

  localparam int IBITS = btb_idx_bits(ENTRIES);
  localparam int IW    = btb_idx_w(ENTRIES);
  localparam int TW    = btb_tag_w(XLEN, ENTRIES);

  typedef struct packed {
    logic            valid;
    logic [TW-1:0]   tag;
    logic [XLEN-1:0] target;
  } entry_t;

  entry_t          mem [ENTRIES];
  logic [IW-1:0]   rd_idx;
  logic [IW-1:0]   wr_idx;
  logic [TW-1:0]   rd_tag;
  logic [TW-1:0]   wr_tag;
  entry_t          rd_entry;
  logic [XLEN-1:0] idx_mask;

  assign idx_mask = XLEN'(ENTRIES - 1);
  assign rd_idx   = IW'((lookup_pc >> 2) & idx_mask);
  assign wr_idx   = IW'((upd_pc >> 2) & idx_mask);
  assign rd_tag   = TW'(lookup_pc >> (IBITS + 2));
  assign wr_tag   = TW'(upd_pc >> (IBITS + 2));

  // Lookup on the current PC against the registered table contents.
  always_comb begin
    rd_entry = mem[rd_idx];
    hit      = rd_entry.valid && (rd_entry.tag == rd_tag);
    target   = hit ? rd_entry.target : '0;
  end

  // Table update; flush takes precedence over any same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) mem[i].valid <= 1'b0;
    end else if (upd_v) begin
      if (upd_taken) begin
        mem[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: upd_target & ~XLEN'(3)};
      end else begin
        mem[wr_idx].valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pcu_btb_fetch.sv
// kv32 fetch-stage program counter with valid/ready handshake, trap/branch
// redirect (trap first) and optional BTB next-PC prediction.
//
// state | meaning
// BOOT  | after reset, pc_v low, waiting for en; redirects ignored
// RUN   | fetching; accept, redirect and en gating active
module pcu_btb_fetch
  import kv32_pcu_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] INIT_ADDR   = '0,
  parameter int              BTB_ENTRIES = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            trap_v,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            br_v,
  input  logic [XLEN-1:0] br_addr,
  input  logic            btb_upd_v,
  input  logic [XLEN-1:0] btb_upd_pc,
  input  logic [XLEN-1:0] btb_upd_target,
  input  logic            btb_upd_taken,
  input  logic            btb_flush,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_p4,
  output logic            pc_v,
  input  logic            pc_rdy,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  fsm_e            state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_v_q, pc_v_d;
  redirect_src_e   rd_src;

  assign pc    = pc_q;
  assign pc_v  = pc_v_q;
  assign pc_p4 = pc_q + XLEN'(PC_STEP);

  // Trap outranks branch; a losing branch request is simply dropped.
  always_comb begin
    rd_src = RD_NONE;
    if (trap_v)    rd_src = RD_TRAP;
    else if (br_v) rd_src = RD_BR;
  end

  // Next-state, next-PC and valid computation.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc_v_d  = pc_v_q;
    case (state_q)
      BOOT: begin
        pc_v_d = 1'b0;
        if (en) begin
          state_d = RUN;
          pc_v_d  = 1'b1;
        end
      end
      RUN: begin
        case (rd_src)
          RD_TRAP: begin
            pc_d   = trap_addr & ~XLEN'(3);
            pc_v_d = en;
          end
          RD_BR: begin
            pc_d   = br_addr & ~XLEN'(3);
            pc_v_d = en;
          end
          default: begin
            if (en) begin
              if (pc_v_q && pc_rdy) pc_d = pred_taken ? pred_target : pc_p4;
              pc_v_d = 1'b1;
            end else begin
              pc_v_d = 1'b0;
            end
          end
        endcase
      end
      default: state_d = BOOT;
    endcase
  end

  // State, PC and valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= INIT_ADDR;
      pc_v_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc_v_q  <= pc_v_d;
    end
  end

  generate
    if (BTB_ENTRIES > 0) begin : g_btb
      pcu_btb #(
        .XLEN    (XLEN),
        .ENTRIES (BTB_ENTRIES)
      ) u_btb (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_pc  (pc_q),
        .hit        (pred_taken),
        .target     (pred_target),
        .upd_v      (btb_upd_v),
        .upd_pc     (btb_upd_pc),
        .upd_target (btb_upd_target),
        .upd_taken  (btb_upd_taken),
        .flush      (btb_flush)
      );
    end else begin : g_no_btb
      logic unused_btb;
      assign unused_btb  = ^{btb_upd_v, btb_upd_pc, btb_upd_target, btb_upd_taken, btb_flush};
      assign pred_taken  = 1'b0;
      assign pred_target = '0;
    end
  endgenerate

endmodule

// File: tb/tb_pcu_btb_fetch.sv
// Bench for pcu_btb_fetch: directed vector table, hand sequences for reset
// and wrap, then random traffic against a behavioural model.
module tb_pcu_btb_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en, trap_v, br_v, btb_upd_v, btb_upd_taken, btb_flush, pc_rdy;
  logic [31:0] trap_addr, br_addr, btb_upd_pc, btb_upd_target;
  logic [31:0] pc, pc_p4, pred_target;
  logic        pc_v, pred_taken;
  logic [31:0] pc0, pc_p40, pred_target0;
  logic        pc_v0, pred_taken0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pcu_btb_fetch #(.XLEN(32), .INIT_ADDR(32'h0), .BTB_ENTRIES(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .trap_v(trap_v), .trap_addr(trap_addr),
    .br_v(br_v), .br_addr(br_addr), .btb_upd_v(btb_upd_v), .btb_upd_pc(btb_upd_pc),
    .btb_upd_target(btb_upd_target), .btb_upd_taken(btb_upd_taken), .btb_flush(btb_flush),
    .pc(pc), .pc_p4(pc_p4), .pc_v(pc_v), .pc_rdy(pc_rdy),
    .pred_taken(pred_taken), .pred_target(pred_target));

  pcu_btb_fetch #(.XLEN(32), .INIT_ADDR(32'h0), .BTB_ENTRIES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .trap_v(trap_v), .trap_addr(trap_addr),
    .br_v(br_v), .br_addr(br_addr), .btb_upd_v(btb_upd_v), .btb_upd_pc(btb_upd_pc),
    .btb_upd_target(btb_upd_target), .btb_upd_taken(btb_upd_taken), .btb_flush(btb_flush),
    .pc(pc0), .pc_p4(pc_p40), .pc_v(pc_v0), .pc_rdy(pc_rdy),
    .pred_taken(pred_taken0), .pred_target(pred_target0));

  // Behavioural model of the 8-entry configuration.
  bit          m_run, m_pcv;
  logic [31:0] m_pc;
  bit          m_val [8];
  logic [31:0] m_tag [8];
  logic [31:0] m_tgt [8];

  function automatic bit m_hit();
    int i = int'((m_pc / 4) % 8);
    return m_val[i] && (m_tag[i] == m_pc / 32);
  endfunction

  function automatic logic [31:0] m_target();
    return m_hit() ? m_tgt[int'((m_pc / 4) % 8)] : 32'h0;
  endfunction

  task automatic model_reset();
    m_run = 0; m_pcv = 0; m_pc = 32'h0;
    for (int i = 0; i < 8; i++) m_val[i] = 0;
  endtask

  task automatic model_step();
    bit          hit = m_hit();
    logic [31:0] tgt = m_target();
    if (!m_run) begin
      if (en) begin m_run = 1; m_pcv = 1; end
    end else if (trap_v) begin
      m_pc = trap_addr - (trap_addr % 4); m_pcv = en;
    end else if (br_v) begin
      m_pc = br_addr - (br_addr % 4); m_pcv = en;
    end else if (en) begin
      if (m_pcv && pc_rdy) m_pc = hit ? tgt : m_pc + 32'd4;
      m_pcv = 1;
    end else begin
      m_pcv = 0;
    end
    if (btb_flush) begin
      for (int i = 0; i < 8; i++) m_val[i] = 0;
    end else if (btb_upd_v) begin
      int i = int'((btb_upd_pc / 4) % 8);
      if (btb_upd_taken) begin
        m_val[i] = 1; m_tag[i] = btb_upd_pc / 32;
        m_tgt[i] = btb_upd_target - (btb_upd_target % 4);
      end else begin
        m_val[i] = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    chk("pc", pc, m_pc);
    chk("pc_p4", pc_p4, m_pc + 32'd4);
    chk("pc_v", {31'b0, pc_v}, {31'b0, m_pcv});
    chk("pred_taken", {31'b0, pred_taken}, {31'b0, m_hit()});
    chk("pred_target", pred_target, m_target());
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    model_compare();
  endtask

  task automatic idle_inputs();
    en = 0; pc_rdy = 0; trap_v = 0; trap_addr = 0; br_v = 0; br_addr = 0;
    btb_upd_v = 0; btb_upd_pc = 0; btb_upd_target = 0; btb_upd_taken = 0; btb_flush = 0;
  endtask

  typedef struct {
    logic        en, rdy, tv;
    logic [31:0] ta;
    logic        bv;
    logic [31:0] ba;
    logic        uv;
    logic [31:0] upc, utgt;
    logic        ut, fl;
    logic [31:0] epc;
    logic        epv, ept;
    logic [31:0] eptgt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic e, logic r, logic tv, logic [31:0] ta, logic bv,
                              logic [31:0] ba, logic uv, logic [31:0] upc, logic [31:0] utgt,
                              logic ut, logic fl, logic [31:0] epc, logic epv, logic ept,
                              logic [31:0] eptgt);
    vec_t v;
    v.en = e; v.rdy = r; v.tv = tv; v.ta = ta; v.bv = bv; v.ba = ba; v.uv = uv;
    v.upc = upc; v.utgt = utgt; v.ut = ut; v.fl = fl;
    v.epc = epc; v.epv = epv; v.ept = ept; v.eptgt = eptgt;
    return v;
  endfunction

  initial begin
    idle_inputs();
    model_reset();
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("reset_pc", pc, 32'h0);
    chk("reset_pc_v", {31'b0, pc_v}, 32'h0);

    //        en rdy tv ta          bv ba           uv upc    utgt   ut fl  epc     pv pt ptgt
    vecs.push_back(mk(0, 0, 0, 0,        0, 0,        0, 0,     0,     0, 0, 32'h0,   0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,        0, 0,        0, 0,     0,     0, 0, 32'h0,   0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,        0, 0,        0, 0,     0,     0, 0, 32'h0,   0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0,        0, 0,        0, 0,     0,     0, 0, 32'h0,   1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0,        0, 0,        0, 0,     0,     0, 0, 32'h4,   1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0,        0, 0,        0, 0,     0,     0, 0, 32'h8,   1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0,        0, 0,        0, 0,     0,     0, 0, 32'hC,   1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0,        0, 0,        0, 0,     0,     0, 0, 32'h10,  1, 0, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 0, 0, 0,      0, 0,        0, 0,     0,     0, 0, 32'h10,  1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0,        0, 0,        0, 0,     0,     0, 0, 32'h14,  1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 32'h100,  1, 32'h200,  0, 0,     0,     0, 0, 32'h100, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,        1, 32'h203,  0, 0,     0,     0, 0, 32'h200, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,        1, 32'h1C,   1, 32'h20, 32'h80, 1, 0, 32'h1C, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0,        0, 0,        0, 0,     0,     0, 0, 32'h20,  1, 1, 32'h80));
    vecs.push_back(mk(1, 1, 0, 0,        0, 0,        0, 0,     0,     0, 0, 32'h80,  1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,        1, 32'h20,   1, 32'h20, 0,     0, 0, 32'h20,  1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0,        0, 0,        0, 0,     0,     0, 0, 32'h24,  1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,        1, 32'h40,   1, 32'h20, 32'h83, 1, 0, 32'h40, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,        1, 32'h20,   0, 0,     0,     0, 0, 32'h20,  1, 1, 32'h80));
    vecs.push_back(mk(1, 0, 0, 0,        1, 32'h88,   1, 32'h88, 32'h100, 1, 1, 32'h88, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,        1, 32'h20,   0, 0,     0,     0, 0, 32'h20,  1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en; pc_rdy = vecs[i].rdy; trap_v = vecs[i].tv; trap_addr = vecs[i].ta;
      br_v = vecs[i].bv; br_addr = vecs[i].ba; btb_upd_v = vecs[i].uv;
      btb_upd_pc = vecs[i].upc; btb_upd_target = vecs[i].utgt;
      btb_upd_taken = vecs[i].ut; btb_flush = vecs[i].fl;
      cycle();
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].epc);
      chk($sformatf("vec%0d_pc_v", i), {31'b0, pc_v}, {31'b0, vecs[i].epv});
      chk($sformatf("vec%0d_pred", i), {31'b0, pred_taken}, {31'b0, vecs[i].ept});
      chk($sformatf("vec%0d_ptgt", i), pred_target, vecs[i].eptgt);
    end

    // Async reset mid-run at pc 0x88.
    idle_inputs();
    en = 1; br_v = 1; br_addr = 32'h88;
    cycle();
    chk("pre_reset_pc", pc, 32'h88);
    br_v = 0;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_pc_v", {31'b0, pc_v}, 32'h0);
    chk("async_pc", pc, 32'h0);
    chk("async_pc_v0", {31'b0, pc_v0}, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_inputs();
    rst_n = 1;

    // Wrap on the no-BTB instance.
    en = 1;
    cycle();
    chk("boot_pc_v0", {31'b0, pc_v0}, 32'h1);
    br_v = 1; br_addr = 32'hFFFF_FFFF;
    cycle();
    chk("wrap_pc0", pc0, 32'hFFFF_FFFC);
    chk("wrap_p40", pc_p40, 32'h0);
    chk("wrap_pred0", {31'b0, pred_taken0}, 32'h0);
    br_v = 0; pc_rdy = 1;
    cycle();
    chk("wrap_acc_pc0", pc0, 32'h0);
    chk("wrap_acc_pred0", {31'b0, pred_taken0}, 32'h0);
    chk("wrap_acc_ptgt0", pred_target0, 32'h0);

    // en low in RUN: valid drops, no accept, redirect still loads.
    en = 0;
    cycle();
    chk("en0_pc_v0", {31'b0, pc_v0}, 32'h0);
    chk("en0_pc0", pc0, 32'h0);
    br_v = 1; br_addr = 32'h300;
    cycle();
    chk("en0_redir_pc0", pc0, 32'h300);
    chk("en0_redir_v0", {31'b0, pc_v0}, 32'h0);
    br_v = 0; en = 1; pc_rdy = 0;
    cycle();
    chk("en1_pc0", pc0, 32'h300);
    chk("en1_v0", {31'b0, pc_v0}, 32'h1);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      en             = ($urandom_range(0, 9) != 0);
      pc_rdy         = $urandom_range(0, 1) != 0;
      trap_v         = ($urandom_range(0, 15) == 0);
      trap_addr      = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 255);
      br_v           = ($urandom_range(0, 7) == 0);
      br_addr        = $urandom_range(0, 255);
      btb_upd_v      = ($urandom_range(0, 3) == 0);
      btb_upd_pc     = $urandom_range(0, 63) * 4;
      btb_upd_target = $urandom_range(0, 255);
      btb_upd_taken  = ($urandom_range(0, 3) != 0);
      btb_flush      = ($urandom_range(0, 63) == 0);
      cycle();
    end

    idle_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
